mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sequential memory-access engine between the multicycle controller/datapath and a word-wide, single-port synchronous RAM. It turns a controller memory request into RAM cycles:
- word loads and stores go straight to the RAM;
- sub-word loads are extracted and extended;
- halfword and byte stores become a read-modify-write sequence.

The controller holds its MEM state until `done` is pulsed.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width (1K words).

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address from ALUOut.
- `wdata`  in  32  store data (B register).
- `storewhb`  in  2  store size: 00 word, 01 half, 10 byte.
- `loadwhb`  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misaligned access; valid only while `done`=1.
- `rdata`  out  32  extended load result; held until the next accepted load.
- `ram_addr`  out  `ADDR_W`  RAM word address, `addr[ADDR_W+1:2]`.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, RD, CAP, MERGE, WR, DONE.
- Acceptance: in IDLE with `req`=1, capture `we`, `addr`, `wdata`, `storewhb` and `loadwhb`. Later changes on those inputs are ignored until the next IDLE.
- Misalignment:
  - a word access with `addr[1:0]`≠0 is misaligned;
  - a half access with `addr[0]`=1 is misaligned;
  - a misaligned access goes IDLE→DONE with `err`=1, never asserts `ram_we`, and leaves `rdata` unchanged.
- Transitions:
  - load: IDLE→RD→CAP→DONE→IDLE.
  - word store: IDLE→WR→DONE→IDLE.
  - half/byte store: IDLE→RD→MERGE→DONE→IDLE.
- Lane mapping is little-endian:
  - byte k = `addr[1:0]` occupies bits [8k+7:8k];
  - half h = `addr[1]` occupies bits [16h+15:16h].
- Load extension:
  - lh and lb sign-extend;
  - lhu and lbu zero-extend;
  - lw passes the word through.
  - In CAP, `rdata` is registered from `ram_rdata`.
- Store merge: in MERGE, `ram_wdata` equals `ram_rdata` with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`. All other lanes are unchanged.
- Write enable: `ram_we`=1 only in WR and MERGE. In WR, `ram_wdata`=`wdata`.
- Address: `ram_addr` comes from the captured address in RD, CAP, WR and MERGE, and is 0 in IDLE.
- `done`=1 only in DONE. `busy`=0 in IDLE.
- A `req` asserted during DONE is ignored. It is accepted on the following IDLE cycle if still high.
- `storewhb`=11 or `loadwhb`>100 is treated as a word access.
- Reset:
  - Reset in any state forces IDLE on the next edge, with no `done` pulse.
  - A write already presented in the reset cycle completes at the RAM. No further RAM cycles are issued.
  - Reset values: `busy`, `done`, `err`, `ram_we` = 0; `rdata`, `ram_addr`, `ram_wdata` = 0.

## Timing
- Acceptance edge is cycle 0.
- Load: RD at cycle 1, CAP at 2, `done` at cycle 3 with `rdata` valid.
- Word store: `ram_we` at cycle 1, `done` at cycle 2.
- Sub-word store: read at cycle 1, merged write at cycle 2, `done` at cycle 3.
- Misaligned access: `done`+`err` at cycle 1.
- Minimum spacing between acceptances is 3, 4 or 2 cycles, since DONE always returns to IDLE.
- All outputs are decoded from registered state and captured fields. There is no combinational path from `req` to any output.

## Structure
- Package `mem_access_pkg` holds:
  - the FSM state enum;
  - `ST_WORD`/`ST_HALF`/`ST_BYTE` (2-bit);
  - `LD_W`/`LD_H`/`LD_HU`/`LD_B`/`LD_BU` (3-bit).
- Sub-module `mem_lane_align` is purely combinational. It performs load extraction/extension and store-lane merge from the word, `addr[1:0]`, size and data. It is shared by CAP and MERGE.
- The top module holds the FSM, the capture registers and `rdata`.

## Test plan
- lb, `addr`=0x0000_0007, RAM word 1 = 0x80FF_1234 → `rdata`=0xFFFF_FF80 at cycle 3, `err`=0.
- lhu, `addr`=0x6, same word → `rdata`=0x0000_80FF. lh at the same address → `rdata`=0xFFFF_80FF.
- sb, `addr`=0x5, `wdata`=0xAAAA_AA5A, RAM word 1 = 0x1122_3344 → `ram_we` only at cycle 2, word becomes 0x1122_5A44, `done` at cycle 3.
- sw, `addr`=0x8, `wdata`=0xDEAD_BEEF → `ram_we` at cycle 1 with `ram_addr`=2, `done` at cycle 2. A read-back lw returns 0xDEAD_BEEF.
- lw at `addr`=0x2 and sh at `addr`=0x3 → `done`+`err` at cycle 1, `ram_we` never asserted, `rdata` unchanged.
- `rst` asserted during RD of an sh → IDLE next cycle, no `ram_we`, no `done`. Then `req` held high through a DONE cycle → exactly one extra acceptance, after IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and encodings for the memory access unit
// Purpose: FSM state enum, store-size and load-type encodings.
// Ports: none (package).
package mem_access_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_MERGE,
      S_WR,
      S_DONE
   } state_e;

   localparam logic [1:0] ST_WORD = 2'b00;
   localparam logic [1:0] ST_HALF = 2'b01;
   localparam logic [1:0] ST_BYTE = 2'b10;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_HU = 3'b010;
   localparam logic [2:0] LD_B  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian load extraction and store lane merge
// Purpose: combinational lane logic shared by the load-capture and store-merge states.
// Ports: word_i (RAM word), off_i (byte offset), st_size_i (store size),
//        ld_type_i (load type), wdata_i (store data),
//        ld_data_o (extended load value), st_data_o (merged store word).
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  st_size_i,
   input  logic [2:0]  ld_type_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (off_i)
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         2'd3:    byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      case (ld_type_i)
         LD_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
         LD_HU:   ld_data_o = {16'h0000, half_sel};
         LD_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   ld_data_o = {24'h000000, byte_sel};
         default: ld_data_o = word_i;
      endcase

      // Start from the old word so only the addressed lane changes.
      st_data_o = word_i;
      case (st_size_i)
         ST_HALF: begin
            if (off_i[1]) st_data_o[31:16] = wdata_i[15:0];
            else          st_data_o[15:0]  = wdata_i[15:0];
         end
         ST_BYTE: begin
            case (off_i)
               2'd1:    st_data_o[15:8]  = wdata_i[7:0];
               2'd2:    st_data_o[23:16] = wdata_i[7:0];
               2'd3:    st_data_o[31:24] = wdata_i[7:0];
               default: st_data_o[7:0]   = wdata_i[7:0];
            endcase
         end
         default: st_data_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential memory access engine for a single-port word RAM
// Purpose: turns controller load/store requests into RAM cycles, with read-modify-write
//          for sub-word stores and extraction/extension for sub-word loads.
// Ports: clk, rst (sync active-high); req/we/addr/wdata/storewhb/loadwhb request side;
//        busy/done/err/rdata status and load result; ram_addr/ram_we/ram_wdata/ram_rdata RAM side.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        storewhb,
   input  logic [2:0]        loadwhb,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   state_e              state_q, state_d;
   logic                we_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [1:0]          st_q;
   logic [2:0]          ld_q;
   logic                err_q;
   logic [31:0]         rdata_q;

   logic [1:0]          st_norm;
   logic [2:0]          ld_norm;
   logic                is_word, is_half, misal;
   logic [31:0]         ld_data, st_data;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^addr[31:ADDR_W+2];

   // Undefined size encodings collapse to word accesses before capture.
   always_comb begin
      st_norm = (storewhb == 2'b11) ? ST_WORD : storewhb;
      ld_norm = (loadwhb > LD_BU) ? LD_W : loadwhb;
      is_word = we ? (st_norm == ST_WORD) : (ld_norm == LD_W);
      is_half = we ? (st_norm == ST_HALF) : ((ld_norm == LD_H) || (ld_norm == LD_HU));
      misal   = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
   end

   always_comb begin
      state_d   = state_q;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      err       = (state_q == S_DONE) && err_q;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (misal)                          state_d = S_DONE;
               else if (we && (st_norm == ST_WORD)) state_d = S_WR;
               else                                state_d = S_RD;
            end
         end
         S_RD: begin
            ram_addr = addr_q[ADDR_W+1:2];
            state_d  = we_q ? S_MERGE : S_CAP;
         end
         S_CAP: begin
            ram_addr = addr_q[ADDR_W+1:2];
            state_d  = S_DONE;
         end
         S_MERGE: begin
            ram_addr  = addr_q[ADDR_W+1:2];
            ram_we    = 1'b1;
            ram_wdata = st_data;
            state_d   = S_DONE;
         end
         S_WR: begin
            ram_addr  = addr_q[ADDR_W+1:2];
            ram_we    = 1'b1;
            ram_wdata = wdata_q;
            state_d   = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         st_q    <= ST_WORD;
         ld_q    <= LD_W;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && req) begin
            we_q    <= we;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            st_q    <= st_norm;
            ld_q    <= ld_norm;
            err_q   <= misal;
         end
         if (state_q == S_CAP) rdata_q <= ld_data;
      end
   end

   assign rdata = rdata_q;

   // RAM data in CAP/MERGE is the word addressed during RD.
   mem_lane_align u_align (
      .word_i    (ram_rdata),
      .off_i     (addr_q[1:0]),
      .st_size_i (st_q),
      .ld_type_i (ld_q),
      .wdata_i   (wdata_q),
      .ld_data_o (ld_data),
      .st_data_o (st_data)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit
module tb_mem_access_unit;
   import mem_access_pkg::*;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst, req, we;
   logic [31:0]       addr, wdata;
   logic [1:0]        storewhb;
   logic [2:0]        loadwhb;
   logic              busy, done, err;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata, ram_rdata;

   logic [31:0] mem [0:1023];
   logic [31:0] model_mem [0:1023];

   typedef struct {
      string             tag;
      bit                exp_err;
      logic [31:0]       exp_rdata;
      int                acc;
      int                exp_lat;
      int                exp_we_cyc;
      logic [ADDR_W-1:0] exp_we_addr;
   } exp_t;

   exp_t sb[$];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int total_we = 0;
   int we_cnt = 0;
   int we_cyc = 0;
   logic [ADDR_W-1:0] we_addr_seen;
   logic [31:0] last_rd = 32'h0;

   mem_access_unit #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .storewhb  (storewhb),
      .loadwhb   (loadwhb),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_store(input logic [31:0] old, input logic [1:0] a,
                                           input logic [1:0] st, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      if (st == ST_BYTE) begin
         sh = 8 * int'(a);
         mask = 32'h0000_00FF << sh;
      end else if (st == ST_HALF) begin
         sh = 16 * int'(a[1]);
         mask = 32'h0000_FFFF << sh;
      end else begin
         return wd;
      end
      return (old & ~mask) | ((wd << sh) & mask);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] ld);
      logic [31:0] sb_w, sh_w;
      sb_w = w >> (8 * int'(a));
      sh_w = w >> (16 * int'(a[1]));
      case (ld)
         LD_B:    return 32'($signed(sb_w[7:0]));
         LD_BU:   return {24'h0, sb_w[7:0]};
         LD_H:    return 32'($signed(sh_w[15:0]));
         LD_HU:   return {16'h0, sh_w[15:0]};
         default: return w;
      endcase
   endfunction

   // Scoreboard consumer: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (ram_we) begin
         total_we++;
         we_cnt++;
         we_addr_seen = ram_addr;
         if (sb.size() > 0) we_cyc = cyc - sb[0].acc + 1;
      end
      if (done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'h0);
         end else begin
            e = sb.pop_front();
            check({e.tag, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.exp_lat));
            check({e.tag, "_err"}, 32'(err), 32'(e.exp_err));
            check({e.tag, "_rdata"}, rdata, e.exp_rdata);
            check({e.tag, "_we_cnt"}, 32'(we_cnt), (e.exp_we_cyc != 0) ? 32'h1 : 32'h0);
            if (e.exp_we_cyc != 0) begin
               check({e.tag, "_we_cyc"}, 32'(we_cyc), 32'(e.exp_we_cyc));
               check({e.tag, "_we_addr"}, 32'(we_addr_seen), 32'(e.exp_we_addr));
            end
         end
         we_cnt = 0;
      end
   end

   task automatic wait_done(input string tag);
      bit got_done;
      got_done = 1'b0;
      for (int i = 0; i < 12 && !got_done; i++) begin
         @(negedge clk);
         got_done = done;
      end
      if (!got_done) check({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   task automatic do_access(input string tag, input bit w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] st, input logic [2:0] ld,
                            input bit exp_err, input logic [31:0] exp_ld);
      exp_t e;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = wd; storewhb = st; loadwhb = ld;
      @(posedge clk);
      #1;
      // Scramble the request inputs: the unit must work from its captured copy.
      req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = ~wd;
      e.tag = tag;
      e.acc = cyc;
      e.exp_err = exp_err;
      e.exp_we_cyc = 0;
      e.exp_we_addr = a[ADDR_W+1:2];
      if (exp_err) begin
         e.exp_lat = 1;
      end else if (w && (st == ST_HALF || st == ST_BYTE)) begin
         e.exp_lat = 3;
         e.exp_we_cyc = 2;
      end else if (w) begin
         e.exp_lat = 2;
         e.exp_we_cyc = 1;
      end else begin
         e.exp_lat = 3;
         last_rd = exp_ld;
      end
      e.exp_rdata = last_rd;
      sb.push_back(e);
      wait_done(tag);
      @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      exp_t e;
      int base, tmp_done, tmp_we, wi;
      logic [1:0] off, st;
      logic [2:0] ld;
      logic [31:0] d, ex;

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
      storewhb = ST_WORD; loadwhb = LD_W;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      rst = 1'b0;

      do_access("sw_4", 1, 32'h4, 32'h80FF_1234, ST_WORD, LD_W, 0, 0);
      do_access("lb_7", 0, 32'h7, 0, ST_WORD, LD_B, 0, 32'hFFFF_FF80);
      do_access("lhu_6", 0, 32'h6, 0, ST_WORD, LD_HU, 0, 32'h0000_80FF);
      do_access("lh_6", 0, 32'h6, 0, ST_WORD, LD_H, 0, 32'hFFFF_80FF);
      do_access("lbu_4", 0, 32'h4, 0, ST_WORD, LD_BU, 0, 32'h0000_0034);
      do_access("lb_5", 0, 32'h5, 0, ST_WORD, LD_B, 0, 32'h0000_0012);

      do_access("sw_4b", 1, 32'h4, 32'h1122_3344, ST_WORD, LD_W, 0, 0);
      do_access("sb_5", 1, 32'h5, 32'hAAAA_AA5A, ST_BYTE, LD_W, 0, 0);
      check("sb_5_mem", mem[1], 32'h1122_5A44);
      do_access("lw_4", 0, 32'h4, 0, ST_WORD, LD_W, 0, 32'h1122_5A44);

      do_access("sw_8", 1, 32'h8, 32'hDEAD_BEEF, ST_WORD, LD_W, 0, 0);
      do_access("lw_8", 0, 32'h8, 0, ST_WORD, LD_W, 0, 32'hDEAD_BEEF);

      do_access("lw_2_mis", 0, 32'h2, 0, ST_WORD, LD_W, 1, 0);
      do_access("sh_3_mis", 1, 32'h3, 32'h5555_5555, ST_HALF, LD_W, 1, 0);
      do_access("lh_1_mis", 0, 32'h1, 0, ST_WORD, LD_H, 1, 0);
      check("mis_mem1", mem[1], 32'h1122_5A44);

      do_access("sh_6", 1, 32'h6, 32'h1234_BEEF, ST_HALF, LD_W, 0, 0);
      do_access("lw_4_sh", 0, 32'h4, 0, ST_WORD, LD_W, 0, 32'hBEEF_5A44);

      do_access("sw11_c", 1, 32'hC, 32'h0123_4567, 2'b11, LD_W, 0, 0);
      do_access("lw7_c", 0, 32'hC, 0, ST_WORD, 3'b111, 0, 32'h0123_4567);

      // Reset during RD of a halfword store: no write, no done.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h6; wdata = 32'h0000_7777; storewhb = ST_HALF;
      @(posedge clk);
      #1;
      req = 1'b0;
      tmp_done = done_cnt;
      tmp_we = total_we;
      @(negedge clk);
      check("rst_mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_idle", 32'(busy), 32'h0);
      check("rst_mid_rdata", rdata, 32'h0);
      repeat (4) @(negedge clk);
      check("rst_mid_no_done", 32'(done_cnt), 32'(tmp_done));
      check("rst_mid_no_we", 32'(total_we), 32'(tmp_we));
      last_rd = 32'h0;
      we_cnt = 0;
      do_access("lw_4_rst", 0, 32'h4, 0, ST_WORD, LD_W, 0, 32'hBEEF_5A44);

      // req held high through DONE: exactly one re-acceptance, one cycle after DONE.
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h8; storewhb = ST_WORD; loadwhb = LD_W;
      @(posedge clk);
      #1;
      base = cyc;
      tmp_done = done_cnt;
      last_rd = 32'hDEAD_BEEF;
      e.tag = "held1"; e.acc = base; e.exp_err = 0; e.exp_lat = 3; e.exp_we_cyc = 0;
      e.exp_we_addr = '0; e.exp_rdata = last_rd;
      sb.push_back(e);
      e.tag = "held2"; e.acc = base + 4;
      sb.push_back(e);
      wait_done("held1");
      @(posedge clk);
      @(negedge clk);
      check("held_idle_gap", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      req = 1'b0;
      check("held_reaccept", 32'(busy), 32'h1);
      wait_done("held2");
      @(posedge clk);
      repeat (4) @(negedge clk);
      check("held_two_done", 32'(done_cnt - tmp_done), 32'h2);

      // Randomised sub-word traffic against a reference memory model.
      for (int i = 16; i < 24; i++) begin
         model_mem[i] = $urandom;
         do_access("rnd_sw", 1, 32'(i * 4), model_mem[i], ST_WORD, LD_W, 0, 0);
      end
      for (int k = 0; k < 16; k++) begin
         wi = $urandom_range(16, 23);
         d = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            st = ($urandom_range(0, 1) == 1) ? ST_HALF : ST_BYTE;
            off = 2'($urandom_range(0, 3));
            if (st == ST_HALF) off[0] = 1'b0;
            model_mem[wi] = m_store(model_mem[wi], off, st, d);
            do_access("rnd_st", 1, 32'(wi * 4) + 32'(off), d, st, LD_W, 0, 0);
         end else begin
            ld = 3'($urandom_range(0, 4));
            off = 2'($urandom_range(0, 3));
            if (ld == LD_W) off = 2'b00;
            if (ld == LD_H || ld == LD_HU) off[0] = 1'b0;
            ex = m_load(model_mem[wi], off, ld);
            do_access("rnd_ld", 0, 32'(wi * 4) + 32'(off), 0, ST_WORD, ld, 0, ex);
         end
      end
      for (int i = 16; i < 24; i++) check("rnd_mem", mem[i], model_mem[i]);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
